// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS receive path: FSM encoding, FIFO and counter sizes.
package lvds_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_e;

  localparam int unsigned FIFO_DEPTH          = 2;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned COUNT_W             = 16;

endpackage

// File: rtl/ff_synch.sv
// Multi-flop synchronizer for a single-bit level crossing into clk_sys.
module ff_synch #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through STAGES flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/lvds_rx_sys.sv
// System-domain back end of the LVDS receiver: 4-phase req/ack capture of deserialized
// words into a 2-entry FIFO, valid/ready output, word counter and sticky protocol error.
module lvds_rx_sys
  import lvds_pkg::*;
#(
  parameter int unsigned PARALLEL_WIDTH = 8,
  parameter int unsigned SERIAL_RATIO   = 8,
  parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [PARALLEL_WIDTH-1:0] rx_parallel_word,
  input  logic                      rx_word_valid,
  output logic                      ack_sys,
  output logic [PARALLEL_WIDTH-1:0] rx_data_out,
  output logic                      rx_data_valid,
  input  logic                      rx_data_ready,
  output logic [COUNT_W-1:0]        rx_word_count,
  output logic                      proto_err
);

  // SERIAL_RATIO only documents the serializer ratio; reject nonsense at elaboration.
  if (SERIAL_RATIO == 0 || PARALLEL_WIDTH == 0) begin : g_param_check
    $error("lvds_rx_sys: SERIAL_RATIO and PARALLEL_WIDTH must be nonzero");
  end

  logic                      req_sync;
  logic                      req_sync_prev_q;
  rx_state_e                 state_q;
  logic                      ack_q;
  logic                      err_q;
  logic [PARALLEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                count_q;
  logic [COUNT_W-1:0]        word_count_q;
  logic [COUNT_W-1:0]        word_count_d;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;

  ff_synch #(
    .STAGES (SYNC_STAGES)
  ) u_req_synch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (rx_word_valid),
    .q       (req_sync)
  );

  // Push eligibility uses the pre-pop count, so a pop on a full FIFO defers the push a cycle.
  always_comb begin
    fifo_full    = (count_q == 2'(FIFO_DEPTH));
    push         = (state_q == S_IDLE) && req_sync && !fifo_full;
    pop          = (count_q != 2'd0) && rx_data_ready;
    word_count_d = word_count_q + COUNT_W'(push);
  end

  // Handshake FSM with registered ack and sticky protocol error.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      ack_q           <= 1'b0;
      err_q           <= 1'b0;
      req_sync_prev_q <= 1'b0;
    end else begin
      req_sync_prev_q <= req_sync;
      unique case (state_q)
        S_IDLE: begin
          if (req_sync && !fifo_full) begin
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else if (req_sync_prev_q && !req_sync) begin
            // Request withdrawn while still waiting for FIFO space.
            err_q <= 1'b1;
          end
        end
        S_ACK: begin
          if (!req_sync) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Two-entry FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= rx_parallel_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Accepted-word counter, wraps modulo 2^COUNT_W.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign ack_sys       = ack_q;
  assign proto_err     = err_q;
  assign rx_data_out   = mem_q[rd_ptr_q];
  assign rx_data_valid = (count_q != 2'd0);
  assign rx_word_count = word_count_q;

endmodule

// File: tb/tb_lvds_rx_sys.sv
// Self-checking bench for lvds_rx_sys: handshake latency, backpressure, ordering,
// protocol error, counter wrap and reset mid-handshake.
module tb_lvds_rx_sys;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int          LAT = SS + 1;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] rx_parallel_word = '0;
  logic         rx_word_valid = 1'b0;
  logic         ack_sys;
  logic [W-1:0] rx_data_out;
  logic         rx_data_valid;
  logic         rx_data_ready = 1'b0;
  logic [15:0]  rx_word_count;
  logic         proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model: words accepted in order, words delivered, expected counter.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [15:0]  model_count = '0;

  lvds_rx_sys #(
    .PARALLEL_WIDTH (W),
    .SERIAL_RATIO   (8),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .rx_parallel_word (rx_parallel_word),
    .rx_word_valid    (rx_word_valid),
    .ack_sys          (ack_sys),
    .rx_data_out      (rx_data_out),
    .rx_data_valid    (rx_data_valid),
    .rx_data_ready    (rx_data_ready),
    .rx_word_count    (rx_word_count),
    .proto_err        (proto_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every word that will be popped on the coming rising edge.
  always @(negedge clk_sys) begin
    #1;
    if (reset_n && rx_data_valid && rx_data_ready) got_q.push_back(rx_data_out);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic bit queues_equal();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Serial-side full 4-phase handshake; timeouts count as failures.
  task automatic handshake(input logic [W-1:0] w, input int limit);
    int n;
    @(negedge clk_sys);
    rx_parallel_word = w;
    rx_word_valid    = 1'b1;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!ack_sys && n < limit);
    checks++;
    if (!ack_sys) begin
      errors++;
      $display("FAIL hs_ack_rise: ack_sys=%0b after %0d cycles, required 1", ack_sys, n);
    end else begin
      exp_q.push_back(w);
      model_count++;
    end
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (ack_sys && n < limit);
    checks++;
    if (ack_sys) begin
      errors++;
      $display("FAIL hs_ack_fall: ack_sys=%0b after %0d cycles, required 0", ack_sys, n);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks += 5;
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b, required 0", ack_sys); end
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", rx_data_valid); end
    if (rx_data_out !== '0) begin errors++; $display("FAIL reset_data: got %0h, required 0", rx_data_out); end
    if (rx_word_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0h, required 0", rx_word_count); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b, required 0", proto_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_single(input logic [W-1:0] w);
    int n;
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready    = 1'b1;
    rx_parallel_word = w;
    rx_word_valid    = 1'b1;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!ack_sys && n < 20);
    checks += 3;
    if (n != LAT) begin errors++; $display("FAIL single_ack_latency: got %0d edges, required %0d", n, LAT); end
    if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b, required 1", rx_data_valid); end
    if (rx_data_out !== w) begin errors++; $display("FAIL single_data: got %0h, required %0h", rx_data_out, w); end
    exp_q.push_back(w);
    model_count++;
    @(posedge clk_sys); #1;
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle: got %0b, required 0", rx_data_valid); end
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (ack_sys && n < 20);
    checks += 3;
    if (n != LAT) begin errors++; $display("FAIL single_ack_fall_latency: got %0d edges, required %0d", n, LAT); end
    if (rx_word_count !== model_count) begin errors++; $display("FAIL single_count: got %0h, required %0h", rx_word_count, model_count); end
    if (!queues_equal()) begin errors++; $display("FAIL single_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready = 1'b0;
    handshake(8'h11, 50);
    handshake(8'h22, 50);
    @(negedge clk_sys);
    rx_parallel_word = 8'h33;
    rx_word_valid    = 1'b1;
    repeat (8) @(posedge clk_sys);
    #1;
    checks += 2;
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL bp_ack_withheld: got %0b, required 0", ack_sys); end
    if (rx_data_out !== 8'h11) begin errors++; $display("FAIL bp_head: got %0h, required 11", rx_data_out); end
    @(negedge clk_sys);
    rx_data_ready = 1'b1;
    @(posedge clk_sys); #1;
    checks++;
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL bp_ack_at_pop: got %0b, required 0", ack_sys); end
    @(posedge clk_sys); #1;
    checks++;
    if (ack_sys !== 1'b1) begin errors++; $display("FAIL bp_ack_after_pop: got %0b, required 1", ack_sys); end
    else begin exp_q.push_back(8'h33); model_count++; end
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk_sys);
    #1;
    checks += 3;
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL bp_ack_fall: got %0b, required 0", ack_sys); end
    if (!queues_equal()) begin errors++; $display("FAIL bp_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
    if (rx_word_count !== model_count) begin errors++; $display("FAIL bp_count: got %0h, required %0h", rx_word_count, model_count); end
  endtask

  task automatic test_simul_push_pop();
    logic [W-1:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready = 1'b0;
    handshake(a, 50);
    @(negedge clk_sys);
    rx_parallel_word = b;
    rx_word_valid    = 1'b1;
    repeat (LAT - 1) @(posedge clk_sys);
    @(negedge clk_sys);
    rx_data_ready = 1'b1;
    @(posedge clk_sys); #1;
    checks += 3;
    if (ack_sys !== 1'b1) begin errors++; $display("FAIL simul_ack: got %0b, required 1", ack_sys); end
    if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %0b, required 1", rx_data_valid); end
    if (rx_data_out !== b) begin errors++; $display("FAIL simul_data: got %0h, required %0h", rx_data_out, b); end
    exp_q.push_back(b);
    model_count++;
    @(posedge clk_sys); #1;
    checks++;
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL simul_count1: valid=%0b, required 0", rx_data_valid); end
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk_sys);
    #1;
    checks++;
    if (!queues_equal()) begin errors++; $display("FAIL simul_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    clear_queues();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_sys);
          handshake(8'($urandom), 200);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk_sys);
          rx_data_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk_sys);
    rx_data_ready = 1'b1;
    repeat (6) @(posedge clk_sys);
    #1;
    checks += 3;
    if (!queues_equal()) begin errors++; $display("FAIL random_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
    if (rx_word_count !== model_count) begin errors++; $display("FAIL random_count: got %0h, required %0h", rx_word_count, model_count); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL random_no_err: got %0b, required 0", proto_err); end
  endtask

  task automatic test_wrap();
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready = 1'b1;
    force dut.word_count_q = 16'hfffe;
    @(negedge clk_sys);
    release dut.word_count_q;
    model_count = 16'hfffe;
    handshake(8'($urandom), 50);
    checks++;
    if (rx_word_count !== 16'hffff) begin errors++; $display("FAIL wrap_ffff: got %0h, required ffff", rx_word_count); end
    handshake(8'($urandom), 50);
    checks += 2;
    if (rx_word_count !== model_count) begin errors++; $display("FAIL wrap_0000: got %0h, required %0h", rx_word_count, model_count); end
    if (!queues_equal()) begin errors++; $display("FAIL wrap_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_proto_err();
    logic [15:0] cnt_before;
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready = 1'b0;
    handshake(8'($urandom), 50);
    handshake(8'($urandom), 50);
    cnt_before = model_count;
    @(negedge clk_sys);
    rx_parallel_word = 8'($urandom);
    rx_word_valid    = 1'b1;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    checks += 3;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %0b, required 1", proto_err); end
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL perr_no_ack: got %0b, required 0", ack_sys); end
    if (rx_word_count !== cnt_before) begin errors++; $display("FAIL perr_count: got %0h, required %0h", rx_word_count, cnt_before); end
    @(negedge clk_sys);
    rx_data_ready = 1'b1;
    repeat (6) @(posedge clk_sys);
    #1;
    checks += 2;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b, required 1", proto_err); end
    if (!queues_equal()) begin errors++; $display("FAIL perr_order: got %0d words, required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int n;
    w = 8'($urandom_range(1, 255));
    clear_queues();
    @(negedge clk_sys);
    rx_data_ready    = 1'b0;
    rx_parallel_word = w;
    rx_word_valid    = 1'b1;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!ack_sys && n < 20);
    checks++;
    if (ack_sys !== 1'b1) begin errors++; $display("FAIL rmid_pre_ack: got %0b, required 1", ack_sys); end
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (ack_sys !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %0b, required 0", ack_sys); end
    if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b, required 0", rx_data_valid); end
    if (rx_data_out !== '0) begin errors++; $display("FAIL rmid_data: got %0h, required 0", rx_data_out); end
    if (rx_word_count !== 16'h0) begin errors++; $display("FAIL rmid_count: got %0h, required 0", rx_word_count); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %0b, required 0", proto_err); end
    model_count = '0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!ack_sys && n < 20);
    model_count++;
    checks += 4;
    if (n != LAT) begin errors++; $display("FAIL rmid_recapture_latency: got %0d edges, required %0d", n, LAT); end
    if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL rmid_recapture_valid: got %0b, required 1", rx_data_valid); end
    if (rx_data_out !== w) begin errors++; $display("FAIL rmid_recapture_data: got %0h, required %0h", rx_data_out, w); end
    if (rx_word_count !== model_count) begin errors++; $display("FAIL rmid_recapture_count: got %0h, required %0h", rx_word_count, model_count); end
    @(negedge clk_sys);
    rx_word_valid = 1'b0;
    rx_data_ready = 1'b1;
    repeat (LAT + 2) @(posedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    for (int i = 0; i < 3; i++) test_single(8'($urandom));
    test_backpressure();
    test_simul_push_pop();
    test_random();
    test_wrap();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
